control_alu_md: RTL and testbench
=================================

# control_alu_md

Next-generation EX-stage ALU control for the MIPS pipeline. Decodes `i_ALUOp`/`i_Funct`/`i_Opcode` into the 4-bit ALU operation, now including shifts, unsigned compares, XORI and LUI. Adds a multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers, MTHI/MTLO/MFHI/MFLO support and a pipeline stall output. It sits between the ID/EX register and the ALU/result mux.

## Interface
- `NB_DATA`, 32, operand/HI/LO width; iteration count of the mul/div engine
- `ANBITS`, 6, funct/opcode width
- `NBITSCONTROL`, 2, main-control ALUOp width
- `ALUOP`, 4, ALU operation code width
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_Valid`  in  1  EX stage holds a valid instruction
- `i_Hold`  in  1  EX held by an external hazard this cycle
- `i_Funct`  in  ANBITS  instruction funct field
- `i_Opcode`  in  ANBITS  instruction opcode
- `i_ALUOp`  in  NBITSCONTROL  main-control class: 00 add, 01 sub, 10 R-type, 11 I-type
- `i_RS`, `i_RT`  in  NB_DATA  forwarded operands
- `o_ALUOp`  out  ALUOP  ALU operation (combinational)
- `o_Illegal`  out  1  unknown funct/opcode for the class (combinational)
- `o_HiLoSel`  out  2  result mux: 00 ALU, 01 HI, 10 LO
- `o_Stall`  out  1  freeze IF/ID/EX (combinational)
- `o_HI`, `o_LO`  out  NB_DATA  HI/LO registers

## Operation
Decode (combinational; a funct or opcode outside these lists gives 1111 with `o_Illegal`=1):
- ALUOp 00 → 0010.
- ALUOp 01 → 0110.
- ALUOp 10, by funct:
  - ADD/ADDU → 0010; SUB/SUBU → 0110; AND → 0000; OR → 0001; NOR → 1100; XOR → 1101; SLT → 0111.
  - SLTU 101011 → 1000; SLL 000000 → 0011; SRL 000010 → 0100; SRA 000011 → 0101.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011 → 0010, legal.
  - MFHI 010000 → `o_HiLoSel`=01; MFLO 010010 → `o_HiLoSel`=10; `o_ALUOp`=0010, legal.
- ALUOp 11, by opcode: SLTI → 0111; ANDI → 0000; ORI → 0001; XORI 001110 → 1101; SLTIU 001011 → 1000; LUI 001111 → 1001.
- `o_HiLoSel`=00 for everything except MFHI/MFLO.

FSM states and transitions:
- IDLE: on `i_Valid` & mul/div funct, latch operand magnitudes (sign-stripped for MULT/DIV, raw for unsigned), record result signs, set count=NB_DATA, go to MUL or DIV.
- MUL: radix-2 shift-add, one bit per cycle, count−1 per cycle. When count reaches 0: write sign-corrected 2·NB_DATA product to {HI,LO}, go to DONE.
- DIV: restoring divide, one quotient bit per cycle. At count 0: LO=quotient (negated if operand signs differ, signed only), HI=remainder (sign of dividend, signed only), go to DONE.
- DONE: stays while `i_Hold`=1, otherwise goes to IDLE. This prevents a held instruction from re-launching.

MTHI/MTLO: HI or LO ← `i_RS` on the edge where state=IDLE, `i_Valid`=1, and the funct matches.

Stall (`o_Stall`=1) when:
- `i_Valid` & mul/div funct & state≠DONE, or
- `i_Valid` & MFHI/MFLO/MTHI/MTLO & state∈{MUL,DIV}.

Boundary cases:
- Divide by zero: LO=all ones, HI=dividend (`i_RS` as latched, sign rules not applied); normal latency.
- DIV of most-negative by −1: LO=100…0, HI=0.
- Reset mid-operation: aborts the operation and clears HI/LO.

## Timing
- Reset values: state IDLE, count 0, `o_HI`=`o_LO`=0, `o_Stall`=0 (with `i_Valid`=0). `o_ALUOp`, `o_Illegal` and `o_HiLoSel` follow their inputs.
- Decode latency: 0 cycles.
- Mul/div latency:
  - Launch edge ends cycle 0.
  - Cycles 1..NB_DATA iterate.
  - HI/LO are written on the edge ending cycle NB_DATA.
  - Cycle NB_DATA+1 is DONE, with `o_Stall`=0.
  - Total stall: NB_DATA+1 cycles (33 at default).
- MFHI in the cycle after DONE sees the new HI; no forwarding is needed.
- `i_Hold` does not pause iteration in MUL/DIV; it only extends DONE.
- A mul/div launched back-to-back after DONE→IDLE starts the next cycle.

## Test plan
- Decode sweep: every listed funct/opcode in each ALUOp class → listed code; funct 111111 with ALUOp 10 → 1111 and `o_Illegal`=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `o_Stall` high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- MFHI presented while DIV is busy → stalls until DONE, then `o_HiLoSel`=01 with the new HI. MTLO 0x1234 in IDLE → LO=0x1234 next cycle.
- `i_Hold`=1 for 3 cycles in DONE → no relaunch; state returns to IDLE only after `i_Hold` falls; HI/LO unchanged.
- `i_reset` low at cycle 10 of a MULT → immediate IDLE, HI=LO=0, `o_Stall`=0 once `i_Valid` drops.

Source files
------------

// File: rtl/control_alu_md.sv
// EX-stage ALU control: instruction decode plus a multi-cycle MULT/DIV sequencer
// that owns the architectural HI/LO registers and the pipeline stall.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no mul/div in flight; launches mul/div, accepts MTHI/MTLO
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result in HI/LO; held here while i_Hold so it cannot relaunch
module control_alu_md #(
  parameter int NB_DATA      = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_Valid,
  input  logic                    i_Hold,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [NB_DATA-1:0]      i_RS,
  input  logic [NB_DATA-1:0]      i_RT,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic                    o_Illegal,
  output logic [1:0]              o_HiLoSel,
  output logic                    o_Stall,
  output logic [NB_DATA-1:0]      o_HI,
  output logic [NB_DATA-1:0]      o_LO
);

  localparam int CW = $clog2(NB_DATA + 1);

  localparam logic [ANBITS-1:0] F_SLL   = 6'b000000;
  localparam logic [ANBITS-1:0] F_SRL   = 6'b000010;
  localparam logic [ANBITS-1:0] F_SRA   = 6'b000011;
  localparam logic [ANBITS-1:0] F_MFHI  = 6'b010000;
  localparam logic [ANBITS-1:0] F_MTHI  = 6'b010001;
  localparam logic [ANBITS-1:0] F_MFLO  = 6'b010010;
  localparam logic [ANBITS-1:0] F_MTLO  = 6'b010011;
  localparam logic [ANBITS-1:0] F_MULT  = 6'b011000;
  localparam logic [ANBITS-1:0] F_MULTU = 6'b011001;
  localparam logic [ANBITS-1:0] F_DIV   = 6'b011010;
  localparam logic [ANBITS-1:0] F_DIVU  = 6'b011011;
  localparam logic [ANBITS-1:0] F_ADD   = 6'b100000;
  localparam logic [ANBITS-1:0] F_ADDU  = 6'b100001;
  localparam logic [ANBITS-1:0] F_SUB   = 6'b100010;
  localparam logic [ANBITS-1:0] F_SUBU  = 6'b100011;
  localparam logic [ANBITS-1:0] F_AND   = 6'b100100;
  localparam logic [ANBITS-1:0] F_OR    = 6'b100101;
  localparam logic [ANBITS-1:0] F_XOR   = 6'b100110;
  localparam logic [ANBITS-1:0] F_NOR   = 6'b100111;
  localparam logic [ANBITS-1:0] F_SLT   = 6'b101010;
  localparam logic [ANBITS-1:0] F_SLTU  = 6'b101011;

  localparam logic [ANBITS-1:0] OP_SLTI  = 6'b001010;
  localparam logic [ANBITS-1:0] OP_SLTIU = 6'b001011;
  localparam logic [ANBITS-1:0] OP_ANDI  = 6'b001100;
  localparam logic [ANBITS-1:0] OP_ORI   = 6'b001101;
  localparam logic [ANBITS-1:0] OP_XORI  = 6'b001110;
  localparam logic [ANBITS-1:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]          count;
  logic [2*NB_DATA-1:0]   acc;
  logic [NB_DATA-1:0]     opnd;
  logic                   neg_q;
  logic                   neg_r;
  logic                   div_zero;

  logic is_r, is_mul, is_div, is_md, is_hilo, signed_op;
  logic is_mthi, is_mtlo, launch, last_step;

  // ---------------- decode ----------------
  always_comb begin
    o_ALUOp   = 4'b1111;
    o_Illegal = 1'b1;
    o_HiLoSel = 2'b00;
    case (i_ALUOp)
      2'b00: begin o_ALUOp = 4'b0010; o_Illegal = 1'b0; end
      2'b01: begin o_ALUOp = 4'b0110; o_Illegal = 1'b0; end
      2'b10: begin
        o_Illegal = 1'b0;
        case (i_Funct)
          F_ADD, F_ADDU:                  o_ALUOp = 4'b0010;
          F_SUB, F_SUBU:                  o_ALUOp = 4'b0110;
          F_AND:                          o_ALUOp = 4'b0000;
          F_OR:                           o_ALUOp = 4'b0001;
          F_NOR:                          o_ALUOp = 4'b1100;
          F_XOR:                          o_ALUOp = 4'b1101;
          F_SLT:                          o_ALUOp = 4'b0111;
          F_SLTU:                         o_ALUOp = 4'b1000;
          F_SLL:                          o_ALUOp = 4'b0011;
          F_SRL:                          o_ALUOp = 4'b0100;
          F_SRA:                          o_ALUOp = 4'b0101;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MTHI, F_MTLO:                 o_ALUOp = 4'b0010;
          F_MFHI: begin o_ALUOp = 4'b0010; o_HiLoSel = 2'b01; end
          F_MFLO: begin o_ALUOp = 4'b0010; o_HiLoSel = 2'b10; end
          default: begin o_ALUOp = 4'b1111; o_Illegal = 1'b1; end
        endcase
      end
      default: begin
        o_Illegal = 1'b0;
        case (i_Opcode)
          OP_SLTI:  o_ALUOp = 4'b0111;
          OP_ANDI:  o_ALUOp = 4'b0000;
          OP_ORI:   o_ALUOp = 4'b0001;
          OP_XORI:  o_ALUOp = 4'b1101;
          OP_SLTIU: o_ALUOp = 4'b1000;
          OP_LUI:   o_ALUOp = 4'b1001;
          default: begin o_ALUOp = 4'b1111; o_Illegal = 1'b1; end
        endcase
      end
    endcase
  end

  assign is_r      = (i_ALUOp == 2'b10);
  assign is_mul    = is_r & ((i_Funct == F_MULT) | (i_Funct == F_MULTU));
  assign is_div    = is_r & ((i_Funct == F_DIV)  | (i_Funct == F_DIVU));
  assign is_md     = is_mul | is_div;
  assign is_mthi   = is_r & (i_Funct == F_MTHI);
  assign is_mtlo   = is_r & (i_Funct == F_MTLO);
  assign is_hilo   = is_mthi | is_mtlo | (is_r & ((i_Funct == F_MFHI) | (i_Funct == F_MFLO)));
  assign signed_op = (i_Funct == F_MULT) | (i_Funct == F_DIV);
  assign launch    = (state == IDLE) & i_Valid & is_md;
  assign last_step = (count == CW'(1));

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_Stall    = 1'b0;
    case (state)
      IDLE: if (launch) state_next = is_mul ? MUL : DIV;
      MUL:  if (last_step) state_next = DONE;
      DIV:  if (last_step) state_next = DONE;
      DONE: if (!i_Hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_Valid & is_md & (state != DONE))
      o_Stall = 1'b1;
    if (i_Valid & is_hilo & ((state == MUL) | (state == DIV)))
      o_Stall = 1'b1;
  end

  // ---------------- iteration datapath ----------------
  logic              a_neg, b_neg;
  logic [NB_DATA-1:0] a_mag, b_mag;
  logic [NB_DATA:0]   mul_sum;
  logic [2*NB_DATA-1:0] mul_next, mul_res;
  logic               div_ge;
  logic [NB_DATA-1:0] div_diff, rem_next, quo_next, quo_res, rem_res;

  assign a_neg = signed_op & i_RS[NB_DATA-1];
  assign b_neg = signed_op & i_RT[NB_DATA-1];
  assign a_mag = a_neg ? -i_RS : i_RS;
  assign b_mag = b_neg ? -i_RT : i_RT;

  // acc = {partial product, remaining multiplier} for MUL, {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[NB_DATA-1:1]};
  assign mul_res  = neg_q ? -mul_next : mul_next;

  // While the remainder stays below the divisor the low-bit subtraction is exact whenever div_ge holds
  assign div_ge   = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]} >= {1'b0, opnd};
  assign div_diff = {acc[2*NB_DATA-2:NB_DATA], acc[NB_DATA-1]} - opnd;
  assign rem_next = div_ge ? div_diff : {acc[2*NB_DATA-2:NB_DATA], acc[NB_DATA-1]};
  assign quo_next = {acc[NB_DATA-2:0], div_ge};
  assign quo_res  = div_zero ? '1 : (neg_q ? -quo_next : quo_next);
  assign rem_res  = neg_r ? -rem_next : rem_next;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      o_HI     <= '0;
      o_LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            count    <= CW'(NB_DATA);
            acc      <= {{NB_DATA{1'b0}}, a_mag};
            opnd     <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (i_RT == '0);
          end else if (i_Valid & is_mthi) begin
            o_HI <= i_RS;
          end else if (i_Valid & is_mtlo) begin
            o_LO <= i_RS;
          end
        end
        MUL: begin
          count <= count - 1'b1;
          acc   <= mul_next;
          if (last_step) {o_HI, o_LO} <= mul_res;
        end
        DIV: begin
          count <= count - 1'b1;
          acc   <= {rem_next, quo_next};
          if (last_step) begin
            o_HI <= rem_res;
            o_LO <= quo_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_alu_md.sv
// Directed bench for control_alu_md: decode table, mul/div results and latency,
// HI/LO moves, hold in DONE and asynchronous reset mid-operation.
module tb_control_alu_md;

  logic        i_clk, i_reset, i_Valid, i_Hold;
  logic [5:0]  i_Funct, i_Opcode;
  logic [1:0]  i_ALUOp;
  logic [31:0] i_RS, i_RT;
  logic [3:0]  o_ALUOp;
  logic        o_Illegal, o_Stall;
  logic [1:0]  o_HiLoSel;
  logic [31:0] o_HI, o_LO;

  int total = 0;
  int bad   = 0;
  int n;

  control_alu_md dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_Valid(i_Valid), .i_Hold(i_Hold),
    .i_Funct(i_Funct), .i_Opcode(i_Opcode), .i_ALUOp(i_ALUOp),
    .i_RS(i_RS), .i_RT(i_RT),
    .o_ALUOp(o_ALUOp), .o_Illegal(o_Illegal), .o_HiLoSel(o_HiLoSel),
    .o_Stall(o_Stall), .o_HI(o_HI), .o_LO(o_LO)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic [1:0] aop, input logic [5:0] fn, input logic [5:0] opc,
                     input logic [3:0] eop, input logic ill, input logic [1:0] sel);
    i_ALUOp  = aop;
    i_Funct  = fn;
    i_Opcode = opc;
    #1;
    chk($sformatf("dec_%b_%b_%b", aop, fn, opc), {o_ALUOp, o_Illegal, o_HiLoSel}, {eop, ill, sel});
  endtask

  // Launch a mul/div and count stalled cycles; returns in the first non-stalled (DONE) cycle
  task automatic run_md(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                        output int cnt);
    @(negedge i_clk);
    i_Valid = 1'b1; i_ALUOp = 2'b10; i_Funct = fn; i_RS = rs; i_RT = rt;
    #1;
    cnt = 0;
    while (o_Stall && cnt < 100) begin
      cnt++;
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic retire();
    @(negedge i_clk);
    i_Valid = 1'b0;
    #1;
  endtask

  initial begin
    i_reset = 1'b0; i_Valid = 1'b0; i_Hold = 1'b0;
    i_Funct = '0; i_Opcode = '0; i_ALUOp = '0; i_RS = '0; i_RT = '0;
    #2;
    chk("rst_stall", o_Stall, 0);
    chk("rst_hi", o_HI, 0);
    chk("rst_lo", o_LO, 0);
    @(negedge i_clk);
    i_reset = 1'b1;

    // decode sweep
    dec(2'b00, 6'b000000, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b01, 6'b000000, 6'b000000, 4'b0110, 0, 2'b00);
    dec(2'b10, 6'b100000, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b100001, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b100010, 6'b000000, 4'b0110, 0, 2'b00);
    dec(2'b10, 6'b100011, 6'b000000, 4'b0110, 0, 2'b00);
    dec(2'b10, 6'b100100, 6'b000000, 4'b0000, 0, 2'b00);
    dec(2'b10, 6'b100101, 6'b000000, 4'b0001, 0, 2'b00);
    dec(2'b10, 6'b100111, 6'b000000, 4'b1100, 0, 2'b00);
    dec(2'b10, 6'b100110, 6'b000000, 4'b1101, 0, 2'b00);
    dec(2'b10, 6'b101010, 6'b000000, 4'b0111, 0, 2'b00);
    dec(2'b10, 6'b101011, 6'b000000, 4'b1000, 0, 2'b00);
    dec(2'b10, 6'b000000, 6'b000000, 4'b0011, 0, 2'b00);
    dec(2'b10, 6'b000010, 6'b000000, 4'b0100, 0, 2'b00);
    dec(2'b10, 6'b000011, 6'b000000, 4'b0101, 0, 2'b00);
    dec(2'b10, 6'b011000, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b011001, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b011010, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b011011, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b010001, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b010011, 6'b000000, 4'b0010, 0, 2'b00);
    dec(2'b10, 6'b010000, 6'b000000, 4'b0010, 0, 2'b01);
    dec(2'b10, 6'b010010, 6'b000000, 4'b0010, 0, 2'b10);
    dec(2'b10, 6'b111111, 6'b000000, 4'b1111, 1, 2'b00);
    dec(2'b11, 6'b000000, 6'b001010, 4'b0111, 0, 2'b00);
    dec(2'b11, 6'b000000, 6'b001100, 4'b0000, 0, 2'b00);
    dec(2'b11, 6'b000000, 6'b001101, 4'b0001, 0, 2'b00);
    dec(2'b11, 6'b000000, 6'b001110, 4'b1101, 0, 2'b00);
    dec(2'b11, 6'b000000, 6'b001011, 4'b1000, 0, 2'b00);
    dec(2'b11, 6'b000000, 6'b001111, 4'b1001, 0, 2'b00);
    dec(2'b11, 6'b010000, 6'b000000, 4'b1111, 1, 2'b00);

    // MTLO / MTHI in IDLE
    @(negedge i_clk);
    i_Valid = 1'b1; i_ALUOp = 2'b10; i_Funct = 6'b010011; i_RS = 32'h0000_1234;
    #1;
    chk("mtlo_stall", o_Stall, 0);
    @(negedge i_clk);
    i_Funct = 6'b010001; i_RS = 32'h0000_ABCD;
    #1;
    chk("mtlo_lo", o_LO, 32'h0000_1234);
    retire();
    chk("mthi_hi", o_HI, 32'h0000_ABCD);
    chk("mthi_lo_kept", o_LO, 32'h0000_1234);

    // multiply / divide results and latency
    run_md(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_stall_cycles", n, 33);
    chk("multu_hilo", {o_HI, o_LO}, 64'hFFFF_FFFE_0000_0001);
    retire();

    run_md(6'b011000, 32'hFFFF_FFFD, 32'h0000_0005, n);
    chk("mult_stall_cycles", n, 33);
    chk("mult_hilo", {o_HI, o_LO}, 64'hFFFF_FFFF_FFFF_FFF1);
    retire();

    run_md(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, n);
    chk("div_stall_cycles", n, 33);
    chk("div_neg_hilo", {o_HI, o_LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    retire();

    run_md(6'b011011, 32'h0000_0007, 32'h0000_0000, n);
    chk("divu_zero_hilo", {o_HI, o_LO}, 64'h0000_0007_FFFF_FFFF);
    retire();

    run_md(6'b011010, 32'hFFFF_FFF9, 32'h0000_0000, n);
    chk("div_zero_neg_hilo", {o_HI, o_LO}, 64'hFFFF_FFF9_FFFF_FFFF);
    retire();

    run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_minneg_hilo", {o_HI, o_LO}, 64'h0000_0000_8000_0000);
    retire();

    run_md(6'b011011, 32'h0000_0064, 32'h0000_0007, n);
    chk("divu_hilo", {o_HI, o_LO}, 64'h0000_0002_0000_000E);
    retire();

    // MFHI arriving while DIV iterates
    @(negedge i_clk);
    i_Valid = 1'b1; i_ALUOp = 2'b10; i_Funct = 6'b011010; i_RS = 32'hFFFF_FF9C; i_RT = 32'h0000_0007;
    #1;
    @(negedge i_clk);
    #1;
    @(negedge i_clk);
    i_Funct = 6'b010000;
    #1;
    n = 0;
    while (o_Stall && n < 100) begin
      n++;
      @(negedge i_clk);
      #1;
    end
    chk("mfhi_busy_stall_cycles", n, 31);
    chk("mfhi_sel", o_HiLoSel, 2'b01);
    chk("mfhi_new_hilo", {o_HI, o_LO}, 64'hFFFF_FFFE_FFFF_FFF2);
    retire();

    // hold in DONE must not relaunch
    run_md(6'b011001, 32'h0000_0006, 32'h0000_0007, n);
    chk("hold_run_cycles", n, 33);
    i_Hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_no_relaunch_%0d", k), o_Stall, 0);
      @(negedge i_clk);
      #1;
    end
    i_Hold = 1'b0;
    #1;
    chk("hold_release_stall", o_Stall, 0);
    chk("hold_hilo", {o_HI, o_LO}, 64'h0000_0000_0000_002A);
    @(negedge i_clk);
    i_Funct = 6'b010011; i_RS = 32'h0000_0055;
    #1;
    @(negedge i_clk);
    i_Funct = 6'b010001; i_RS = 32'h0000_ABCD;
    #1;
    chk("hold_back_to_idle", o_LO, 32'h0000_0055);
    retire();
    chk("pre_reset_hi", o_HI, 32'h0000_ABCD);

    // reset during a MULT
    @(negedge i_clk);
    i_Valid = 1'b1; i_ALUOp = 2'b10; i_Funct = 6'b011000; i_RS = 32'd3; i_RT = 32'd5;
    #1;
    repeat (10) @(negedge i_clk);
    #1;
    chk("mid_mult_stall", o_Stall, 1);
    i_reset = 1'b0;
    #1;
    chk("reset_mid_hilo", {o_HI, o_LO}, 64'h0);
    i_Valid = 1'b0;
    #1;
    chk("reset_mid_stall", o_Stall, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    #1;
    chk("post_reset_hilo", {o_HI, o_LO}, 64'h0);
    chk("post_reset_stall", o_Stall, 0);

    // first launch after reset proves the sequencer restarted from IDLE
    run_md(6'b011001, 32'h0000_0003, 32'h0000_0005, n);
    chk("post_reset_mult_cycles", n, 33);
    chk("post_reset_mult_hilo", {o_HI, o_LO}, 64'h0000_0000_0000_000F);
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
